// File: rtl/avmm_cfg_if.sv
// avmm_cfg_if: Avalon-MM bus between the CPU master port and the config responder
interface avmm_cfg_if;
  logic [7:0] avs_address;
  logic       avs_read;
  logic       avs_write;
  logic [7:0] avs_writedata;
  logic       avs_waitrequest;
  logic [7:0] avs_readdata;
  logic       avs_readdatavalid;
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avmm_cfg_responder.sv
// avmm_cfg_responder: Avalon-MM control/status register block with wait states and pipelined reads
module avmm_cfg_responder #(
  parameter int         NUM_REGS    = 16,
  parameter int         WAIT_STATES = 1,
  parameter int         RD_LATENCY  = 2,
  parameter logic [7:0] BLOCK_ID    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  avmm_cfg_if.slave             avs,
  output logic [NUM_REGS*8-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]   ctrl_wr_strobe,
  input  logic [7:0]            stat_live_in,
  input  logic [7:0]            stat_event_in,
  output logic                  irq
);
  localparam int AW = $clog2(NUM_REGS);
  logic [2:0] wcnt;
  logic [NUM_REGS-1:0][7:0] regs;
  logic [7:0] sticky, mask, err, rd_data, w1c;
  logic req, acc, rd_acc, wr_acc, is_ctrl, rd_ok, wr_ok, err_inc, err_clr;
  logic [AW-1:0] idx;
  logic [RD_LATENCY-1:0] pv;
  logic [RD_LATENCY-1:0][7:0] pd;
  assign req = avs.avs_read | avs.avs_write;
  assign avs.avs_waitrequest = reset | (req & (wcnt != 3'(WAIT_STATES)));
  assign acc = req & ~avs.avs_waitrequest;
  assign rd_acc = acc & avs.avs_read;
  // read+write together is a read; the write half is dropped
  assign wr_acc = acc & avs.avs_write & ~avs.avs_read;
  assign idx = avs.avs_address[AW-1:0];
  assign is_ctrl = avs.avs_address != 8'h00 && avs.avs_address < 8'(NUM_REGS);
  assign wr_ok = is_ctrl | (avs.avs_address inside {8'hF0, 8'hF2, 8'hF3});
  assign rd_ok = wr_ok | (avs.avs_address inside {8'h00, 8'hF1});
  assign rd_data = avs.avs_address == 8'h00 ? BLOCK_ID
                 : is_ctrl                  ? regs[idx]
                 : avs.avs_address == 8'hF0 ? sticky
                 : avs.avs_address == 8'hF1 ? stat_live_in
                 : avs.avs_address == 8'hF2 ? err
                 : avs.avs_address == 8'hF3 ? mask
                 : 8'h00;
  assign err_inc = (rd_acc & (~rd_ok | avs.avs_write)) | (wr_acc & ~wr_ok);
  assign err_clr = wr_acc & avs.avs_address == 8'hF2;
  assign w1c = wr_acc && avs.avs_address == 8'hF0 ? avs.avs_writedata : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt           <= 3'd0;
      regs           <= '0;
      sticky         <= 8'h00;
      mask           <= 8'h00;
      err            <= 8'h00;
      irq            <= 1'b0;
      ctrl_wr_strobe <= '0;
      pv             <= '0;
      pd             <= '0;
    end else begin
      wcnt <= req && avs.avs_waitrequest ? wcnt + 3'd1 : 3'd0;
      if (wr_acc && is_ctrl) regs[idx] <= avs.avs_writedata;
      if (wr_acc && avs.avs_address == 8'hF3) mask <= avs.avs_writedata;
      sticky <= (sticky & ~w1c) | stat_event_in;
      err <= err_clr ? 8'h00 : err_inc && err != 8'hFF ? err + 8'd1 : err;
      irq <= |(sticky & mask);
      ctrl_wr_strobe <= wr_acc && is_ctrl ? NUM_REGS'(1) << idx : '0;
      pv[0] <= rd_acc;
      pd[0] <= rd_acc ? rd_data : 8'h00;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign ctrl_regs = regs;
  assign avs.avs_readdatavalid = pv[RD_LATENCY-1];
  assign avs.avs_readdata = pd[RD_LATENCY-1];
endmodule
